// File: rtl/mul_iter_ctrl.sv
// Sequencer for an iterative radix-2 signed/unsigned multiplier driving one external (W+1)-bit adder.
// Latency: request accepted at cycle 0, o_valid rises at cycle W+2 (one add per CALC cycle, W+1 of them).
// Backpressure: o_ready only in IDLE; the result is held in DONE until i_ready, i_flush or i_rst.
module mul_iter_ctrl #(
    parameter int W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [1:0]   i_op,
    input  logic         i_word,
    input  logic [W-1:0] i_src1,
    input  logic [W-1:0] i_src2,
    input  logic         i_flush,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_result,
    output logic [W:0]   o_add_a,
    output logic [W:0]   o_add_b,
    output logic         o_add_c,
    input  logic [W:0]   i_add_s,
    input  logic         i_add_c
);

    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W:0]    m_q;      // multiplicand, already sign/zero extended
    logic [W:0]    h_q;      // high half of the running product
    logic [W:0]    l_q;      // multiplier bits shifting out, product low bits shifting in
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic          word_q;

    logic          last;
    logic          ext;
    logic [W:0]    h_nxt;
    logic [W:0]    l_nxt;
    logic [W-1:0]  res_nxt;

    assign o_ready = (state == IDLE) && !i_rst;

    // Adder operands, next partial product and the result picked from the post-update product
    always_comb begin
        last    = (state == CALC) && (cnt == CW'(W));
        o_add_a = '0;
        o_add_b = '0;
        o_add_c = 1'b0;
        if ((state == CALC) && !i_rst) begin
            o_add_a = h_q;
            if (l_q[0]) begin
                // The top multiplier bit carries negative weight: subtract M on the final step
                o_add_b = last ? ~m_q : m_q;
                o_add_c = last;
            end
        end
        // True sign of the (W+2)-bit sum, so the arithmetic shift never loses the sign
        ext   = o_add_a[W] ^ o_add_b[W] ^ i_add_c;
        h_nxt = {ext, i_add_s[W:1]};
        l_nxt = {i_add_s[0], l_q[W:1]};
        if (op_q == 2'b00) begin
            if (word_q) begin
                res_nxt = {{(W-32){l_nxt[31]}}, l_nxt[31:0]};
            end else begin
                res_nxt = l_nxt[W-1:0];
            end
        end else begin
            res_nxt = {h_nxt[W-2:0], l_nxt[W]};
        end
    end

    // Control FSM, operand setup, shift-add iteration and result register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            o_valid  <= 1'b0;
            o_result <= '0;
            cnt      <= '0;
            m_q      <= '0;
            h_q      <= '0;
            l_q      <= '0;
            op_q     <= 2'b00;
            word_q   <= 1'b0;
        end else if (i_flush) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        // src1 is signed for MUL/MULH/MULHSU, src2 only for MUL/MULH
                        m_q    <= (i_op != 2'b11) ? {i_src1[W-1], i_src1} : {1'b0, i_src1};
                        l_q    <= (!i_op[1]) ? {i_src2[W-1], i_src2} : {1'b0, i_src2};
                        h_q    <= '0;
                        cnt    <= '0;
                        op_q   <= i_op;
                        word_q <= i_word;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    h_q <= h_nxt;
                    l_q <= l_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state    <= DONE;
                        o_valid  <= 1'b1;
                        o_result <= res_nxt;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_iter_ctrl.md
Name: mul_iter_ctrl

Overview:
Sequencing controller for an iterative radix-2 signed/unsigned multiplier in the EXU mult path. It reuses one external (W+1)-bit ripple-carry adder instance for one add per cycle. The block owns the handshake with the EXU, the operand/sign setup, the partial-product registers, the iteration counter and result selection. The adder sits outside the block: the controller drives its operands and consumes its sum and carry-out in the same cycle.

Parameters:
W, 64, operand/result width (XLEN); the external adder is (W+1) bits wide.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  request valid
o_ready  out  1  controller can accept a request (state IDLE)
i_op  in  2  00 MUL (low W), 01 MULH (s*s high), 10 MULHSU (src1 signed, src2 unsigned, high), 11 MULHU (u*u high)
i_word  in  1  MULW: only valid with i_op=00; result is the sign-extension of product[31:0]
i_src1  in  W  multiplicand
i_src2  in  W  multiplier
i_flush  in  1  kill any in-flight operation
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_result  out  W  result
o_add_a  out  W+1  adder operand A
o_add_b  out  W+1  adder operand B
o_add_c  out  1  adder carry-in
i_add_s  in  W+1  adder sum
i_add_c  in  1  adder carry-out

Behaviour:
- Reset values: state IDLE, o_valid=0, o_result=0, counter=0, registers M/H/L=0. While i_rst is high: o_ready=0 and the adder outputs are 0.
- States are IDLE, CALC and DONE. o_ready=1 only in IDLE.
- IDLE: on i_valid & !i_flush:
  - M = src1 extended to W+1 bits (sign-extend if i_op is 00/01/10, else zero-extend).
  - L = src2 extended to W+1 bits (sign-extend if i_op is 00/01, else zero-extend).
  - H = 0, cnt = 0. Latch op and word. Go to CALC.
- CALC runs for exactly W+1 cycles (cnt 0..W). Let last = (cnt==W).
  - Adder drive: o_add_a = H.
  - o_add_b = 0 if L[0]=0; otherwise M if !last, or ~M if last.
  - o_add_c = last & L[0]. On the last step the multiplier sign bit has negative weight, so the block subtracts.
  - Update each cycle:
    - ext = o_add_a[W] ^ o_add_b[W] ^ i_add_c
    - H <= {ext, i_add_s[W:1]}
    - L <= {i_add_s[0], L[W:1]}
    - cnt <= cnt+1
  - When last: go to DONE and load o_result.
- Result selection, computed from the post-update {H,L} (the 2W+2-bit product P):
  - MUL: P[W-1:0].
  - MULW: sign-extend of P[31:0].
  - MULH/MULHSU/MULHU: P[2W-1:W] = {H[W-2:0], L[W]}.
- DONE: o_valid=1 and o_result is held stable. On i_ready go to IDLE with o_valid=0. A new request is accepted one cycle later, not in the same cycle.
- Latency: accept at cycle 0; o_valid rises at cycle W+2 (66 for W=64). Result is held indefinitely under backpressure.
- i_flush in any state: next state is IDLE, o_valid=0, counter cleared. Flush beats a simultaneous i_valid (not accepted) and a simultaneous i_ready (no handshake counted).
- Synchronous reset mid-operation: same effect as flush, plus the reset values above.
- Counter width is clog2(W+2). There is no wrap: CALC exits at cnt==W.
- The adder outputs are purely combinational from the registers. Outside CALC, o_add_a, o_add_b and o_add_c are 0.

Test Plan:
- MUL 3 x 5 -> o_result=15. o_valid rises exactly 66 cycles after accept. o_ready is low throughout.
- MULH 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF -> 0. MULHU with the same operands -> 0xFFFF_FFFF_FFFF_FFFE. MUL with the same operands -> 1.
- MULHSU src1=0xFFFF_FFFF_FFFF_FFFF (-1), src2=2 -> 0xFFFF_FFFF_FFFF_FFFF. MULH 0x8000_0000_0000_0000 x 0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000.
- MULW 0x7FFF_FFFF x 2 -> 0xFFFF_FFFF_FFFF_FFFE. MULW with src1 upper bits set to garbage gives an identical result.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_result stay stable, and i_valid is ignored. Release -> handshake, then IDLE.
- Flush at cnt=20, with i_valid high in the same cycle -> IDLE next cycle, no o_valid, no accept. A following MUL 7 x 9 -> 63 with full latency. Assert i_rst at cnt=40 -> same recovery.
